uart_tx_framed: RTL and testbench



---
 rtl/uart_tx_framed.sv | 185 ++++++++++++++++++
 tb/tb_uart_tx_framed.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_framed.sv
// Parametrised UART transmitter with input FIFO: start, DATA_BITS LSB-first, optional parity, 1/2 stop.
// Latency: word accepted into an empty FIFO at edge N drives the start bit from edge N+1.
// Backpressure: s_ready = !full; a full FIFO refuses a push even when a pop happens that same cycle.
`timescale 1ns/1ps
module uart_tx_framed #(
   parameter int CLK_FREQ   = 50_000_000,
   parameter int BAUD_RATE  = 9600,
   parameter int DATA_BITS  = 8,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic [DATA_BITS-1:0]               s_data,
   input  logic                               s_valid,
   output logic                               s_ready,
   output logic                               tx,
   output logic                               tx_busy,
   output logic                               tx_done,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count
);

   localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
   localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int ADDR_W       = $clog2(FIFO_DEPTH);
   localparam int PTR_W        = ADDR_W + 1;
   localparam int CNT_OUT_W    = $clog2(FIFO_DEPTH + 1);
   localparam int BIT_W        = 4;
   // Encoding 3 is treated like "no parity"
   localparam bit HAS_PARITY   = (PARITY == 1) || (PARITY == 2);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } state_t;

   // FIFO storage and pointers (extra MSB distinguishes full from empty)
   logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
   logic [DATA_BITS-1:0] mem_d [FIFO_DEPTH];
   logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
   logic                 full, empty, push, pop;
   logic [DATA_BITS-1:0] rd_word;
   logic                 par_bit;

   // Transmit FSM state and registered line outputs
   state_t               state_q, state_d;
   logic [CNT_W-1:0]     baud_cnt_q, baud_cnt_d;
   logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 par_q, par_d;
   logic                 tx_q, tx_d;
   logic                 tx_busy_q, tx_busy_d;
   logic                 tx_done_q, tx_done_d;
   logic                 tick;

   assign s_ready    = !full;
   assign tx         = tx_q;
   assign tx_busy    = tx_busy_q;
   assign tx_done    = tx_done_q;
   assign fifo_count = CNT_OUT_W'(wr_ptr_q - rd_ptr_q);

   // FIFO status, head word, parity of the head word and next pointer/storage values
   always_comb begin
      empty   = (wr_ptr_q == rd_ptr_q);
      full    = (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]) &&
                (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);
      push    = s_valid && !full;
      rd_word = mem_q[rd_ptr_q[ADDR_W-1:0]];
      par_bit = (PARITY == 1) ? ~^rd_word : ^rd_word;
      mem_d   = mem_q;
      if (push) begin
         mem_d[wr_ptr_q[ADDR_W-1:0]] = s_data;
      end
      wr_ptr_d = wr_ptr_q + PTR_W'(push);
      rd_ptr_d = rd_ptr_q + PTR_W'(pop);
   end

   // Frame sequencing: bit timing, state transitions, pops and next registered outputs
   always_comb begin
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      shift_d    = shift_q;
      par_d      = par_q;
      tx_done_d  = 1'b0;
      pop        = 1'b0;
      tick       = (baud_cnt_q == CNT_W'(CLKS_PER_BIT - 1));
      baud_cnt_d = (state_q == ST_IDLE || tick) ? '0 : baud_cnt_q + CNT_W'(1);

      case (state_q)
         ST_IDLE: begin
            pop = !empty;
         end
         ST_START: begin
            if (tick) begin
               state_d   = ST_DATA;
               bit_cnt_d = '0;
            end
         end
         ST_DATA: begin
            if (tick) begin
               shift_d = shift_q >> 1;
               if (bit_cnt_q == BIT_W'(DATA_BITS - 1)) begin
                  bit_cnt_d = '0;
                  state_d   = HAS_PARITY ? ST_PARITY : ST_STOP;
               end else begin
                  bit_cnt_d = bit_cnt_q + BIT_W'(1);
               end
            end
         end
         ST_PARITY: begin
            if (tick) begin
               state_d   = ST_STOP;
               bit_cnt_d = '0;
            end
         end
         ST_STOP: begin
            if (tick) begin
               if (bit_cnt_q == BIT_W'(STOP_BITS - 1)) begin
                  tx_done_d = 1'b1;
                  pop       = !empty;
                  state_d   = ST_IDLE;
               end else begin
                  bit_cnt_d = bit_cnt_q + BIT_W'(1);
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // A pop (from IDLE or straight out of the last stop bit) loads the next frame
      if (pop) begin
         state_d    = ST_START;
         shift_d    = rd_word;
         par_d      = par_bit;
         bit_cnt_d  = '0;
         baud_cnt_d = '0;
      end

      case (state_d)
         ST_START:  tx_d = 1'b0;
         ST_DATA:   tx_d = shift_d[0];
         ST_PARITY: tx_d = par_d;
         default:   tx_d = 1'b1;
      endcase
      tx_busy_d = (state_d != ST_IDLE);
   end

   // All state updates; FIFO storage is not reset since the pointers define its contents
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         state_q    <= ST_IDLE;
         baud_cnt_q <= '0;
         bit_cnt_q  <= '0;
         shift_q    <= '0;
         par_q      <= 1'b0;
         tx_q       <= 1'b1;
         tx_busy_q  <= 1'b0;
         tx_done_q  <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         state_q    <= state_d;
         baud_cnt_q <= baud_cnt_d;
         bit_cnt_q  <= bit_cnt_d;
         shift_q    <= shift_d;
         par_q      <= par_d;
         tx_q       <= tx_d;
         tx_busy_q  <= tx_busy_d;
         tx_done_q  <= tx_done_d;
      end
      for (int i = 0; i < FIFO_DEPTH; i++) begin
         mem_q[i] <= mem_d[i];
      end
   end

endmodule

// File: tb/tb_uart_tx_framed.sv
`timescale 1ns/1ps
module tb_uart_tx_framed;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n;
   logic [3:0] sv;
   logic [7:0] sd0, sd1, sd2;
   logic [4:0] sd3;
   logic [3:0] srdy, txw, busyw, donew;
   logic [2:0] fc0, fc1, fc2, fc3;

   int checks = 0;
   int errors = 0;

   logic txlog   [0:1023];
   logic busylog [0:1023];
   logic donelog [0:1023];

   // 8N1, 10 clocks per bit
   uart_tx_framed #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(8), .PARITY(0),
                    .STOP_BITS(1), .FIFO_DEPTH(4)) u0 (
      .clk(clk), .rst_n(rst_n), .s_data(sd0), .s_valid(sv[0]), .s_ready(srdy[0]),
      .tx(txw[0]), .tx_busy(busyw[0]), .tx_done(donew[0]), .fifo_count(fc0));
   // 8O2
   uart_tx_framed #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(8), .PARITY(1),
                    .STOP_BITS(2), .FIFO_DEPTH(4)) u1 (
      .clk(clk), .rst_n(rst_n), .s_data(sd1), .s_valid(sv[1]), .s_ready(srdy[1]),
      .tx(txw[1]), .tx_busy(busyw[1]), .tx_done(donew[1]), .fifo_count(fc1));
   // 8E2
   uart_tx_framed #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(8), .PARITY(2),
                    .STOP_BITS(2), .FIFO_DEPTH(4)) u2 (
      .clk(clk), .rst_n(rst_n), .s_data(sd2), .s_valid(sv[2]), .s_ready(srdy[2]),
      .tx(txw[2]), .tx_busy(busyw[2]), .tx_done(donew[2]), .fifo_count(fc2));
   // 5N1
   uart_tx_framed #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(5), .PARITY(0),
                    .STOP_BITS(1), .FIFO_DEPTH(4)) u3 (
      .clk(clk), .rst_n(rst_n), .s_data(sd3), .s_valid(sv[3]), .s_ready(srdy[3]),
      .tx(txw[3]), .tx_busy(busyw[3]), .tx_done(donew[3]), .fifo_count(fc3));

   function automatic logic [2:0] get_fc(input int k);
      case (k)
         0:       return fc0;
         1:       return fc1;
         2:       return fc2;
         default: return fc3;
      endcase
   endfunction

   task automatic set_in(input int k, input logic v, input logic [7:0] d);
      sv[k] = v;
      case (k)
         0:       sd0 = d;
         1:       sd1 = d;
         2:       sd2 = d;
         default: sd3 = d[4:0];
      endcase
   endtask

   task automatic test_reset();
      logic [6:0] obs;
      rst_n = 1'b0;
      sv    = '0;
      sd0 = '0; sd1 = '0; sd2 = '0; sd3 = '0;
      repeat (3) @(negedge clk);
      for (int k = 0; k < 4; k++) begin
         obs = {txw[k], busyw[k], donew[k], srdy[k], get_fc(k)};
         checks++;
         if (obs !== 7'b1001000) begin
            errors++;
            $display("FAIL reset_state u%0d: {tx,busy,done,ready,count}=%b expected 1001000", k, obs);
         end
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   // One frame on instance k; exp holds line bits in send order (bit 0 first)
   task automatic test_frame(input int k, input logic [7:0] data, input logic [15:0] exp,
                             input int nbits, input string name);
      int len, bad, nbusy, ndone;
      logic first;
      len = nbits * 10;
      @(negedge clk);
      set_in(k, 1'b1, data);
      @(negedge clk);
      sv[k] = 1'b0;
      checks++;
      if (txw[k] !== 1'b1 || busyw[k] !== 1'b0 || get_fc(k) !== 3'd1) begin
         errors++;
         $display("FAIL %s accept_cycle: tx=%b busy=%b count=%0d expected tx=1 busy=0 count=1",
                  name, txw[k], busyw[k], get_fc(k));
      end
      for (int i = 0; i < len + 5; i++) begin
         @(negedge clk);
         txlog[i]   = txw[k];
         busylog[i] = busyw[k];
         donelog[i] = donew[k];
      end
      for (int b = 0; b < nbits; b++) begin
         bad   = 0;
         first = exp[b];
         for (int s = 0; s < 10; s++) begin
            if (txlog[b*10+s] !== exp[b]) begin
               if (bad == 0) first = txlog[b*10+s];
               bad++;
            end
         end
         checks++;
         if (bad != 0) begin
            errors++;
            $display("FAIL %s line_bit%0d: tx=%b in %0d of 10 cycles, expected %b",
                     name, b, first, bad, exp[b]);
         end
      end
      nbusy = 0;
      ndone = 0;
      for (int i = 0; i < len + 5; i++) begin
         if (busylog[i] === 1'b1) nbusy++;
         if (donelog[i] === 1'b1) ndone++;
      end
      checks++;
      if (busylog[0] !== 1'b1 || nbusy != len) begin
         errors++;
         $display("FAIL %s busy_len: first=%b cycles=%0d expected first=1 cycles=%0d",
                  name, busylog[0], nbusy, len);
      end
      checks++;
      if (ndone != 1 || donelog[len] !== 1'b1) begin
         errors++;
         $display("FAIL %s done_pulse: pulses=%0d at_end=%b expected pulses=1 at_end=1",
                  name, ndone, donelog[len]);
      end
      checks++;
      if (txlog[len] !== 1'b1 || busylog[len] !== 1'b0) begin
         errors++;
         $display("FAIL %s idle_after: tx=%b busy=%b expected tx=1 busy=0",
                  name, txlog[len], busylog[len]);
      end
   endtask

   // Push lands on the same edge as the STOP->START pop with two words queued
   task automatic test_push_pop_same_cycle();
      logic [7:0] w [4];
      logic [9:0] got;
      int st, ndone;
      w = '{8'h3C, 8'hC3, 8'h81, 8'h7E};
      for (int k = 0; k <= 410; k++) begin
         @(negedge clk);
         txlog[k]   = txw[0];
         donelog[k] = donew[0];
         if (k <= 2) set_in(0, 1'b1, w[k]);
         if (k == 3) begin
            sv[0] = 1'b0;
            checks++;
            if (fc0 !== 3'd2) begin
               errors++;
               $display("FAIL pushpop_setup: count=%0d expected 2", fc0);
            end
         end
         if (k == 101) begin
            checks++;
            if (fc0 !== 3'd2) begin
               errors++;
               $display("FAIL pushpop_before: count=%0d expected 2", fc0);
            end
            set_in(0, 1'b1, w[3]);
         end
         if (k == 102) begin
            sv[0] = 1'b0;
            checks++;
            if (fc0 !== 3'd2 || donew[0] !== 1'b1 || txw[0] !== 1'b0) begin
               errors++;
               $display("FAIL pushpop_edge: count=%0d done=%b tx=%b expected count=2 done=1 tx=0",
                        fc0, donew[0], txw[0]);
            end
         end
      end
      for (int f = 0; f < 4; f++) begin
         st = 2 + 100 * f;
         got[0] = txlog[st + 5];
         for (int b = 0; b < 8; b++) got[b+1] = txlog[st + 15 + 10 * b];
         got[9] = txlog[st + 95];
         checks++;
         if (got !== {1'b1, w[f], 1'b0}) begin
            errors++;
            $display("FAIL pushpop_frame%0d: line=%b expected %b", f, got, {1'b1, w[f], 1'b0});
         end
      end
      ndone = 0;
      for (int k = 0; k <= 410; k++) if (donelog[k] === 1'b1) ndone++;
      checks++;
      if (ndone != 4) begin
         errors++;
         $display("FAIL pushpop_done_count: pulses=%0d expected 4", ndone);
      end
   endtask

   // Six words offered continuously into a depth-4 FIFO
   task automatic test_back_to_back();
      logic [7:0] w [6];
      logic [9:0] got;
      int idx, st, ndone, gaps, maxfc;
      logic rdy_prev, saw_full;
      w = '{8'h01, 8'h80, 8'hFF, 8'h00, 8'h5A, 8'hC6};
      idx = 0; rdy_prev = 1'b0; saw_full = 1'b0; maxfc = 0;
      for (int k = 0; k <= 660; k++) begin
         @(negedge clk);
         txlog[k]   = txw[0];
         busylog[k] = busyw[0];
         donelog[k] = donew[0];
         if (sv[0] && rdy_prev) idx++;
         if (int'(fc0) > maxfc) maxfc = int'(fc0);
         if (srdy[0] === 1'b0) saw_full = 1'b1;
         if (idx < 6) set_in(0, 1'b1, w[idx]);
         else         sv[0] = 1'b0;
         rdy_prev = srdy[0];
      end
      checks++;
      if (maxfc != 4 || !saw_full) begin
         errors++;
         $display("FAIL b2b_fill: max_count=%0d ready_dropped=%b expected 4 and 1", maxfc, saw_full);
      end
      checks++;
      if (idx != 6) begin
         errors++;
         $display("FAIL b2b_accepted: words=%0d expected 6", idx);
      end
      for (int f = 0; f < 6; f++) begin
         st = 2 + 100 * f;
         got[0] = txlog[st + 5];
         for (int b = 0; b < 8; b++) got[b+1] = txlog[st + 15 + 10 * b];
         got[9] = txlog[st + 95];
         checks++;
         if (got !== {1'b1, w[f], 1'b0}) begin
            errors++;
            $display("FAIL b2b_frame%0d: line=%b expected %b", f, got, {1'b1, w[f], 1'b0});
         end
      end
      gaps = 0;
      for (int k = 2; k <= 601; k++) if (busylog[k] !== 1'b1) gaps++;
      checks++;
      if (gaps != 0 || busylog[602] !== 1'b0) begin
         errors++;
         $display("FAIL b2b_no_gap: idle_cycles=%0d busy_after=%b expected 0 and 0", gaps, busylog[602]);
      end
      ndone = 0;
      for (int k = 0; k <= 660; k++) if (donelog[k] === 1'b1) ndone++;
      checks++;
      if (ndone != 6) begin
         errors++;
         $display("FAIL b2b_done_count: pulses=%0d expected 6", ndone);
      end
   endtask

   // Reset while the second queued word is in its data bits
   task automatic test_reset_mid_frame();
      logic [7:0] w [3];
      int lows, ndone;
      w = '{8'hF0, 8'h0F, 8'hAA};
      for (int k = 0; k <= 400; k++) begin
         @(negedge clk);
         txlog[k]   = txw[0];
         donelog[k] = donew[0];
         if (k <= 2) set_in(0, 1'b1, w[k]);
         if (k == 3) sv[0] = 1'b0;
         if (k == 150) begin
            checks++;
            if (busyw[0] !== 1'b1 || fc0 !== 3'd1 || txlog[105] !== 1'b0) begin
               errors++;
               $display("FAIL rst_mid_pre: busy=%b count=%0d start2=%b expected 1,1,0",
                        busyw[0], fc0, txlog[105]);
            end
            rst_n = 1'b0;
         end
         if (k == 151) begin
            checks++;
            if (txw[0] !== 1'b1 || busyw[0] !== 1'b0) begin
               errors++;
               $display("FAIL rst_mid_line: tx=%b busy=%b expected tx=1 busy=0", txw[0], busyw[0]);
            end
            checks++;
            if (fc0 !== 3'd0 || srdy[0] !== 1'b1) begin
               errors++;
               $display("FAIL rst_mid_fifo: count=%0d ready=%b expected 0 and 1", fc0, srdy[0]);
            end
            rst_n = 1'b1;
         end
      end
      lows = 0;
      ndone = 0;
      for (int k = 152; k <= 400; k++) begin
         if (txlog[k] !== 1'b1) lows++;
         if (donelog[k] === 1'b1) ndone++;
      end
      checks++;
      if (lows != 0 || ndone != 0) begin
         errors++;
         $display("FAIL rst_mid_dropped: low_cycles=%0d done_pulses=%0d expected 0 and 0", lows, ndone);
      end
   endtask

   initial begin
      test_reset();
      test_frame(0, 8'hA5, {6'b0, 1'b1, 8'hA5, 1'b0}, 10, "8n1");
      test_frame(1, 8'hA5, {4'b0, 2'b11, 1'b1, 8'hA5, 1'b0}, 12, "8o2");
      test_frame(2, 8'hA5, {4'b0, 2'b11, 1'b0, 8'hA5, 1'b0}, 12, "8e2");
      test_frame(3, 8'hFF, {9'b0, 1'b1, 5'h1F, 1'b0}, 7, "5n1");
      test_push_pop_same_cycle();
      test_back_to_back();
      test_reset_mid_frame();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
